mem_port_arbiter: RTL and testbench

- Responder end of the fetcher→memory and lsu→memory request interfaces.
- Arbitrates between instruction-fetch and load/store requests.
- Serialises each request into byte accesses on the single 8-bit RAM/IO bus.
- Returns assembled data with a one-cycle finish pulse to the requester.
- Sits between the fetcher/lsu and the cpu top-level memory pins.

---
 rtl/mem_port_arbiter_pkg.sv | 32 +++
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, FSM encodings, access-size codes and IO-space selector for mem_port_arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_TYPE = 32;
    localparam int unsigned DATA_TYPE = 32;
    localparam int unsigned INST_TYPE = 32;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic [1:0] IO_HI_DEFAULT = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StFetch = 2'b01,
        StLoad  = 2'b10,
        StStore = 2'b11
    } state_e;

    // Byte count of an access; the reserved size code behaves as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SIZE_B:  n = 3'd1;
            SIZE_H:  n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store requests onto the 8-bit RAM/IO bus, one byte per cycle.
// Optional MEM_IO_WRITE_GAP_EN: idle bus cycle after every IO-space write byte.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter logic [1:0] IO_HI = IO_HI_DEFAULT
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rdy,
    input  logic                 i_clear,
    input  logic                 i_if_start,
    input  logic [ADDR_TYPE-1:0] i_if_pc,
    output logic                 o_if_finish,
    output logic [INST_TYPE-1:0] o_if_inst,
    input  logic                 i_ls_ena,
    input  logic                 i_ls_wr,
    input  logic [1:0]           i_ls_size,
    input  logic [ADDR_TYPE-1:0] i_ls_addr,
    input  logic [DATA_TYPE-1:0] i_ls_wdata,
    output logic                 o_ls_finish,
    output logic [DATA_TYPE-1:0] o_ls_rdata,
    input  logic [7:0]           i_mem_din,
    output logic [7:0]           o_mem_dout,
    output logic [ADDR_TYPE-1:0] o_mem_a,
    output logic                 o_mem_wr,
    input  logic                 i_io_buffer_full
);

    state_e                r_state;
    state_e                w_state_next;
    logic [2:0]            r_cnt;
    logic [2:0]            r_len;
    logic [ADDR_TYPE-1:0]  r_base;
    logic [DATA_TYPE-1:0]  r_wdata;
    logic [DATA_TYPE-1:0]  r_buf;
    logic                  r_gap;
    logic                  r_if_finish;
    logic                  r_ls_finish;
    logic [INST_TYPE-1:0]  r_if_inst;
    logic [DATA_TYPE-1:0]  r_ls_rdata;

    logic [ADDR_TYPE-1:0]  w_addr;
    logic [2:0]            w_rd_idx;
    logic [1:0]            w_byte_idx;
    logic [DATA_TYPE-1:0]  w_buf_next;
    logic                  w_reading;
    logic                  w_rd_last;
    logic                  w_io;
    logic                  w_stall;
    logic                  w_wr_fire;
    logic                  w_gap_needed;
    logic                  w_st_done;
    logic                  w_accept;

    assign w_addr     = r_base + {29'b0, r_cnt};
    assign w_io       = (w_addr[17:16] == IO_HI);
    assign w_reading  = (r_state == StFetch) || (r_state == StLoad);
    assign w_rd_last  = w_reading && (r_cnt == r_len);
    assign w_stall    = (r_state == StStore) && !r_gap && w_io && i_io_buffer_full;
    assign w_wr_fire  = (r_state == StStore) && !r_gap && !w_stall;
    assign w_byte_idx = r_cnt[1:0] - 2'd1;
    assign w_accept   = !i_clear && !r_if_finish && !r_ls_finish && (i_ls_ena || i_if_start);

`ifdef MEM_IO_WRITE_GAP_EN
    assign w_gap_needed = w_io;
`else
    assign w_gap_needed = 1'b0;
`endif

    assign w_st_done = (w_wr_fire && !w_gap_needed && (r_cnt == r_len - 3'd1))
                     || (r_state == StStore && r_gap && r_cnt == r_len);

    // While frozen, re-present the address whose byte is still pending capture.
    assign w_rd_idx = (!i_rdy && r_cnt != 3'd0) ? r_cnt - 3'd1 : r_cnt;

    always_comb begin
        w_buf_next = r_buf;
        if (w_reading && r_cnt != 3'd0) begin
            w_buf_next[{w_byte_idx, 3'b000} +: 8] = i_mem_din;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else if (i_rdy) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (i_ls_ena) w_state_next = i_ls_wr ? StStore : StLoad;
                    else          w_state_next = StFetch;
                end
            end
            StFetch, StLoad: if (i_clear || w_rd_last) w_state_next = StIdle;
            StStore:         if (w_st_done)            w_state_next = StIdle;
            default:         w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_mem_a    = '0;
        o_mem_dout = '0;
        o_mem_wr   = 1'b0;
        case (r_state)
            StFetch, StLoad: begin
                if (w_rd_idx < r_len) o_mem_a = r_base + {29'b0, w_rd_idx};
            end
            StStore: begin
                if (!r_gap) begin
                    o_mem_a    = w_addr;
                    o_mem_dout = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
                    o_mem_wr   = i_rdy && !w_stall;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt       <= '0;
            r_len       <= '0;
            r_base      <= '0;
            r_wdata     <= '0;
            r_buf       <= '0;
            r_gap       <= 1'b0;
            r_if_finish <= 1'b0;
            r_ls_finish <= 1'b0;
            r_if_inst   <= '0;
            r_ls_rdata  <= '0;
        end else if (i_rdy) begin
            r_if_finish <= (r_state == StFetch) && w_rd_last && !i_clear;
            r_ls_finish <= ((r_state == StLoad) && w_rd_last && !i_clear) || w_st_done;
            case (r_state)
                StIdle: begin
                    r_cnt <= '0;
                    r_gap <= 1'b0;
                    if (w_accept) begin
                        r_base  <= i_ls_ena ? i_ls_addr : i_if_pc;
                        r_len   <= i_ls_ena ? size_bytes(i_ls_size) : 3'd4;
                        r_wdata <= i_ls_wdata;
                        r_buf   <= '0;
                    end
                end
                StFetch, StLoad: begin
                    r_buf <= w_buf_next;
                    r_cnt <= (w_state_next == StIdle) ? 3'd0 : r_cnt + 3'd1;
                    if (w_rd_last && !i_clear) begin
                        if (r_state == StFetch) r_if_inst  <= w_buf_next;
                        else                    r_ls_rdata <= w_buf_next;
                    end
                end
                StStore: begin
                    if (w_st_done) begin
                        r_cnt <= '0;
                        r_gap <= 1'b0;
                    end else if (r_gap) begin
                        r_gap <= 1'b0;
                    end else if (w_wr_fire) begin
                        r_cnt <= r_cnt + 3'd1;
                        r_gap <= w_gap_needed;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_if_finish = r_if_finish;
    assign o_if_inst   = r_if_inst;
    assign o_ls_finish = r_ls_finish;
    assign o_ls_rdata  = r_ls_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: byte-wide RAM model, finish and bus-write queues.
module tb_mem_port_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_rdy;
    logic        i_clear;
    logic        i_if_start;
    logic [31:0] i_if_pc;
    logic        o_if_finish;
    logic [31:0] o_if_inst;
    logic        i_ls_ena;
    logic        i_ls_wr;
    logic [1:0]  i_ls_size;
    logic [31:0] i_ls_addr;
    logic [31:0] i_ls_wdata;
    logic        o_ls_finish;
    logic [31:0] o_ls_rdata;
    logic [7:0]  r_din;
    logic [7:0]  o_mem_dout;
    logic [31:0] o_mem_a;
    logic        o_mem_wr;
    logic        i_io_buffer_full;

    always #5 i_clk = ~i_clk;

    mem_port_arbiter #(.IO_HI(2'b11)) u_dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_rdy            (i_rdy),
        .i_clear          (i_clear),
        .i_if_start       (i_if_start),
        .i_if_pc          (i_if_pc),
        .o_if_finish      (o_if_finish),
        .o_if_inst        (o_if_inst),
        .i_ls_ena         (i_ls_ena),
        .i_ls_wr          (i_ls_wr),
        .i_ls_size        (i_ls_size),
        .i_ls_addr        (i_ls_addr),
        .i_ls_wdata       (i_ls_wdata),
        .o_ls_finish      (o_ls_finish),
        .o_ls_rdata       (o_ls_rdata),
        .i_mem_din        (r_din),
        .o_mem_dout       (o_mem_dout),
        .o_mem_a          (o_mem_a),
        .o_mem_wr         (o_mem_wr),
        .i_io_buffer_full (i_io_buffer_full)
    );

    typedef struct {
        logic [31:0] data;
        int          when;
        bit          has_data;
    } fin_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic [7:0] ram [0:65535];
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;
    fin_t       if_q[$];
    fin_t       ls_q[$];
    wr_t        wr_q[$];

`ifdef MEM_IO_WRITE_GAP_EN
    localparam int IoStoreLat = 6;
`else
    localparam int IoStoreLat = 5;
`endif

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // RAM model: one-cycle read latency, IO space not backed by RAM.
    always @(posedge i_clk) begin
        cyc   <= cyc + 1;
        r_din <= ram[o_mem_a[15:0]];
        if (o_mem_wr && o_mem_a[17:16] != 2'b11) ram[o_mem_a[15:0]] <= o_mem_dout;
    end

    always @(negedge i_clk) begin
        if (i_rst_n && i_rdy && o_if_finish) begin
            if (if_q.size() == 0) begin
                check_eq("if_spurious", 1, 0);
            end else begin
                fin_t e;
                e = if_q.pop_front();
                check_eq("if_time", cyc, e.when);
                check_eq("if_inst", o_if_inst, e.data);
            end
        end
        if (i_rst_n && i_rdy && o_ls_finish) begin
            if (ls_q.size() == 0) begin
                check_eq("ls_spurious", 1, 0);
            end else begin
                fin_t e;
                e = ls_q.pop_front();
                check_eq("ls_time", cyc, e.when);
                if (e.has_data) check_eq("ls_rdata", o_ls_rdata, e.data);
            end
        end
        if (i_rst_n && o_mem_wr) begin
            if (wr_q.size() == 0) begin
                check_eq("wr_spurious", o_mem_a, 0);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                check_eq("wr_addr", o_mem_a, w.addr);
                check_eq("wr_data", o_mem_dout, w.data);
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_fin(input bit is_if);
        int  k = 0;
        bit  seen = 0;
        while (!seen && k < 300) begin
            @(negedge i_clk);
            seen = is_if ? o_if_finish : o_ls_finish;
            k++;
        end
        check_eq(is_if ? "if_handshake" : "ls_handshake", seen, 1);
        tick();
    endtask

    task automatic fetch_req(input logic [31:0] pc, input logic [31:0] exp, input int lat);
        if_q.push_back('{data: exp, when: cyc + lat, has_data: 1'b1});
        i_if_pc    = pc;
        i_if_start = 1'b1;
        wait_fin(1'b1);
        i_if_start = 1'b0;
        i_if_pc    = '0;
    endtask

    task automatic ls_req(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp, input int lat);
        ls_q.push_back('{data: exp, when: cyc + lat, has_data: !wr});
        i_ls_wr    = wr;
        i_ls_size  = size;
        i_ls_addr  = addr;
        i_ls_wdata = wdata;
        i_ls_ena   = 1'b1;
        wait_fin(1'b0);
        i_ls_ena   = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_if_finish"}, o_if_finish, 0);
        check_eq({tag, "_if_inst"},   o_if_inst,   0);
        check_eq({tag, "_ls_finish"}, o_ls_finish, 0);
        check_eq({tag, "_ls_rdata"},  o_ls_rdata,  0);
        check_eq({tag, "_mem_a"},     o_mem_a,     0);
        check_eq({tag, "_mem_wr"},    o_mem_wr,    0);
        check_eq({tag, "_mem_dout"},  o_mem_dout,  0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        i_rst_n = 1'b0; i_rdy = 1'b1; i_clear = 1'b0;
        i_if_start = 1'b0; i_if_pc = '0;
        i_ls_ena = 1'b0; i_ls_wr = 1'b0; i_ls_size = '0; i_ls_addr = '0; i_ls_wdata = '0;
        i_io_buffer_full = 1'b0;
        for (int a = 0; a < 65536; a++) ram[a] <= 8'h00;
        ram[16'h0100] <= 8'h13; ram[16'h0101] <= 8'h05; ram[16'h0102] <= 8'h10; ram[16'h0103] <= 8'h00;
        ram[16'h0200] <= 8'h44; ram[16'h0201] <= 8'h33; ram[16'h0202] <= 8'h22; ram[16'h0203] <= 8'h11;
        ram[16'h0300] <= 8'h0D; ram[16'h0301] <= 8'hF0; ram[16'h0302] <= 8'hFE; ram[16'h0303] <= 8'hCA;
        ram[16'h1FFD] <= 8'hAA; ram[16'h2000] <= 8'h55;
        ram[16'hFFFE] <= 8'h01; ram[16'hFFFF] <= 8'h02; ram[16'h0000] <= 8'h03; ram[16'h0001] <= 8'h04;

        repeat (3) tick();
        check_zero_outputs("rst");
        i_rst_n = 1'b1;
        tick();

        // Fetch with per-cycle address trace.
        fork
            fetch_req(32'h100, 32'h0010_0513, 6);
            begin
                @(negedge i_clk);
                for (int i = 0; i < 4; i++) begin
                    @(negedge i_clk);
                    check_eq("fetch_addr", o_mem_a, 32'h100 + i);
                    check_eq("fetch_wr", o_mem_wr, 0);
                end
            end
        join

        // Load wins over a simultaneous fetch; the fetch follows.
        fork
            ls_req(1'b0, 2'b10, 32'h200, '0, 32'h1122_3344, 6);
            fetch_req(32'h100, 32'h0010_0513, 13);
        join

        ls_req(1'b0, 2'b01, 32'h202, '0, 32'h0000_1122, 4);
        ls_req(1'b0, 2'b00, 32'h201, '0, 32'h0000_0033, 3);
        ls_req(1'b0, 2'b11, 32'h300, '0, 32'hCAFE_F00D, 6);

        wr_q.push_back('{addr: 32'h1FFE, data: 8'hEF});
        wr_q.push_back('{addr: 32'h1FFF, data: 8'hBE});
        ls_req(1'b1, 2'b01, 32'h1FFE, 32'hDEAD_BEEF, '0, 3);
        check_eq("ram_1ffe", ram[16'h1FFE], 8'hEF);
        check_eq("ram_1fff", ram[16'h1FFF], 8'hBE);
        check_eq("ram_1ffd", ram[16'h1FFD], 8'hAA);
        check_eq("ram_2000", ram[16'h2000], 8'h55);

        // IO store stalled by a full buffer for three cycles.
        i_io_buffer_full = 1'b1;
        wr_q.push_back('{addr: 32'h30000, data: 8'h41});
        fork
            ls_req(1'b1, 2'b00, 32'h30000, 32'h0000_0041, '0, IoStoreLat);
            begin
                for (int i = 0; i < 3; i++) begin
                    tick();
                    @(negedge i_clk);
                    check_eq("io_stall_wr", o_mem_wr, 0);
                end
                tick();
                i_io_buffer_full = 1'b0;
            end
        join

        // Fetch flushed after two bytes: no finish may appear.
        i_if_pc    = 32'h100;
        i_if_start = 1'b1;
        repeat (3) tick();
        i_clear    = 1'b1;
        i_if_start = 1'b0;
        tick();
        i_clear    = 1'b0;
        repeat (10) tick();
        fetch_req(32'h300, 32'hCAFE_F00D, 6);

        // Store is immune to clear.
        wr_q.push_back('{addr: 32'h1000, data: 8'h04});
        wr_q.push_back('{addr: 32'h1001, data: 8'h03});
        wr_q.push_back('{addr: 32'h1002, data: 8'h02});
        wr_q.push_back('{addr: 32'h1003, data: 8'h01});
        fork
            ls_req(1'b1, 2'b10, 32'h1000, 32'h0102_0304, '0, 5);
            begin
                repeat (2) tick();
                i_clear = 1'b1;
                tick();
                i_clear = 1'b0;
            end
        join
        check_eq("ram_1003", ram[16'h1003], 8'h01);

        // rdy low for five cycles mid-load and mid-store.
        fork
            ls_req(1'b0, 2'b10, 32'h200, '0, 32'h1122_3344, 11);
            begin
                repeat (2) tick();
                i_rdy = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge i_clk);
                    check_eq("rdy_load_wr", o_mem_wr, 0);
                    tick();
                end
                i_rdy = 1'b1;
            end
        join
        wr_q.push_back('{addr: 32'h2100, data: 8'hC3});
        wr_q.push_back('{addr: 32'h2101, data: 8'hA5});
        fork
            ls_req(1'b1, 2'b01, 32'h2100, 32'h0000_A5C3, '0, 8);
            begin
                tick();
                i_rdy = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge i_clk);
                    check_eq("rdy_store_wr", o_mem_wr, 0);
                    tick();
                end
                i_rdy = 1'b1;
            end
        join
        check_eq("ram_2101", ram[16'h2101], 8'hA5);

        fetch_req(32'hFFFF_FFFE, 32'h0403_0201, 6);

        // Asynchronous reset in the middle of a load.
        i_ls_wr = 1'b0; i_ls_size = 2'b10; i_ls_addr = 32'h200; i_ls_ena = 1'b1;
        repeat (3) tick();
        i_rst_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        i_ls_ena = 1'b0;
        repeat (2) tick();
        i_rst_n = 1'b1;
        tick();
        fetch_req(32'h100, 32'h0010_0513, 6);

        repeat (5) tick();
        check_eq("if_q_drained", if_q.size(), 0);
        check_eq("ls_q_drained", ls_q.size(), 0);
        check_eq("wr_q_drained", wr_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
